// File: rtl/ftdi_fifo_ctrl.sv
// FTDI FT245-style synchronous-to-asynchronous FIFO bridge.
// Moves bytes between the FTDI parallel FIFO pins (RXF#/TXE#/RD#/WR#, shared
// 8-bit bus) and a pair of single-entry valid/ready buffers on the fabric side.
// Reads and writes alternate when both are pending; every transfer is followed
// by a recovery window that also hides the synchronizer delay on RXF#/TXE#.
module ftdi_fifo_ctrl #(
  parameter int RD_PULSE = 4,  // cycles RD# is held low per read (2..15)
  parameter int WR_PULSE = 4,  // cycles WR# is held low per write (2..15)
  parameter int REC      = 3   // recovery cycles after each transfer (3..15)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic       rxf,
  input  logic       txe,
  input  logic [7:0] adbus_in,
  output logic [7:0] adbus_out,
  output logic       adbus_tri,
  output logic       ftdi_rd,
  output logic       ftdi_wr,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_LOW   = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_LOW   = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_REC      = 3'd5
  } state_t;

  // Counters are loaded with (length - 1) and the phase ends on the cycle
  // the counter reads zero, so each phase lasts exactly its length.
  localparam logic [3:0] RD_CNT  = 4'(RD_PULSE - 1);
  localparam logic [3:0] WR_CNT  = 4'(WR_PULSE - 1);
  localparam logic [3:0] REC_CNT = 4'(REC - 1);

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       ftdi_rd_q;
  logic       ftdi_wr_q;
  logic       adbus_tri_q;
  logic       busy_q;
  logic [7:0] adbus_out_q;
  logic       last_rd_q;   // 1 = most recent transfer was a read

  logic       rxf_meta_q;
  logic       rxf_s_q;
  logic       txe_meta_q;
  logic       txe_s_q;

  logic       rx_valid_q;
  logic       rx_valid_d;
  logic [7:0] rx_data_q;
  logic [7:0] rx_data_d;

  logic       hold_full_q;
  logic       hold_full_d;
  logic [7:0] hold_q;
  logic [7:0] hold_d;

  logic       rd_elig_s;
  logic       wr_elig_s;
  logic       rd_done_s;
  logic       wr_done_s;

  assign rd_elig_s = en && !rxf_s_q && !rx_valid_q;
  assign wr_elig_s = en && !txe_s_q && hold_full_q;
  assign rd_done_s = (state_q == ST_RD_LOW) && (cnt_q == 4'd0);
  assign wr_done_s = (state_q == ST_WR_HOLD);

  assign ftdi_rd   = ftdi_rd_q;
  assign ftdi_wr   = ftdi_wr_q;
  assign adbus_tri = adbus_tri_q;
  assign adbus_out = adbus_out_q;
  assign busy      = busy_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign tx_ready  = !hold_full_q;

  // Two-flop synchronizers for the asynchronous FTDI status flags (idle high).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rxf_meta_q <= 1'b1;
      rxf_s_q    <= 1'b1;
      txe_meta_q <= 1'b1;
      txe_s_q    <= 1'b1;
    end else begin
      rxf_meta_q <= rxf;
      rxf_s_q    <= rxf_meta_q;
      txe_meta_q <= txe;
      txe_s_q    <= txe_meta_q;
    end
  end

  // Transfer sequencer with all pin-facing strobes registered in-line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      ftdi_rd_q   <= 1'b1;
      ftdi_wr_q   <= 1'b1;
      adbus_tri_q <= 1'b0;
      adbus_out_q <= 8'h00;
      busy_q      <= 1'b0;
      last_rd_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Read wins unless a write is also pending and the last one was a read.
          if (rd_elig_s && (!wr_elig_s || !last_rd_q)) begin
            state_q   <= ST_RD_LOW;
            cnt_q     <= RD_CNT;
            ftdi_rd_q <= 1'b0;
            busy_q    <= 1'b1;
            last_rd_q <= 1'b1;
          end else if (wr_elig_s) begin
            state_q     <= ST_WR_SETUP;
            adbus_tri_q <= 1'b1;
            adbus_out_q <= hold_q;
            busy_q      <= 1'b1;
            last_rd_q   <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_RD_LOW: begin
          if (cnt_q == 4'd0) begin
            state_q   <= ST_REC;
            cnt_q     <= REC_CNT;
            ftdi_rd_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_WR_SETUP: begin
          state_q   <= ST_WR_LOW;
          cnt_q     <= WR_CNT;
          ftdi_wr_q <= 1'b0;
        end
        ST_WR_LOW: begin
          if (cnt_q == 4'd0) begin
            state_q   <= ST_WR_HOLD;
            ftdi_wr_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_WR_HOLD: begin
          state_q     <= ST_REC;
          cnt_q       <= REC_CNT;
          adbus_tri_q <= 1'b0;
        end
        ST_REC: begin
          if (cnt_q == 4'd0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= 4'd0;
          ftdi_rd_q   <= 1'b1;
          ftdi_wr_q   <= 1'b1;
          adbus_tri_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // RX buffer next state: load at the end of a read, drain on handshake.
  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    if (rd_done_s) begin
      rx_valid_d = 1'b1;
      rx_data_d  = adbus_in;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // RX buffer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
    end else begin
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  // TX holding register next state: empties after WR_HOLD; tx_ready is still
  // low on that cycle, so a clear and a new load never coincide.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_d      = hold_q;
    if (wr_done_s) begin
      hold_full_d = 1'b0;
    end else if (tx_valid && tx_ready) begin
      hold_full_d = 1'b1;
      hold_d      = tx_data;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  // TX holding registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_full_q <= 1'b0;
      hold_q      <= 8'h00;
    end else begin
      hold_full_q <= hold_full_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_ftdi_fifo_ctrl.sv
// Directed bench for ftdi_fifo_ctrl: reset values, read, read latency, write,
// en gating, read/write alternation, reset mid-write, and a random soak with
// pin-protocol monitoring and byte scoreboards.
module tb_ftdi_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic       rxf;
  logic       txe;
  logic [7:0] adbus_in;
  logic [7:0] adbus_out;
  logic       adbus_tri;
  logic       ftdi_rd;
  logic       ftdi_wr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [7:0] ORD_R = 8'd82;
  localparam logic [7:0] ORD_W = 8'd87;

  // Pin monitor state
  int rd_run = 0, wr_run = 0, tri_run = 0;
  int last_rd_len = 0, last_wr_len = 0, last_tri_len = 0;
  int rd_cnt = 0, wr_cnt = 0, viol = 0;
  int quiet_run = 0, min_gap = 99;
  int sb_err = 0, sb_rx_n = 0, sb_tx_n = 0;
  logic seen_act = 1'b0;
  logic prev_rd = 1'b1, prev_wr = 1'b1, prev_tri = 1'b0;
  logic [7:0] rd_exp = 8'h00, wr_obs = 8'h00, tmp_b;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  logic [7:0] order_q[$];

  always #10 clock = ~clock;

  ftdi_fifo_ctrl #(.RD_PULSE(4), .WR_PULSE(4), .REC(3)) dut (
    .clock(clock), .reset(reset), .en(en), .rxf(rxf), .txe(txe),
    .adbus_in(adbus_in), .adbus_out(adbus_out), .adbus_tri(adbus_tri),
    .ftdi_rd(ftdi_rd), .ftdi_wr(ftdi_wr), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pin monitor on the falling edge: protocol invariants, pulse lengths,
  // transfer order, idle gaps and byte scoreboards.
  always @(negedge clock) begin
    if (reset) begin
      rd_run = 0; wr_run = 0; tri_run = 0; quiet_run = 0;
      seen_act = 1'b0;
      prev_rd = 1'b1; prev_wr = 1'b1; prev_tri = 1'b0;
      rxq.delete();
      txq.delete();
    end else begin
      if (!ftdi_rd && adbus_tri) viol++;
      if (!ftdi_rd && !ftdi_wr) viol++;
      if (!ftdi_wr && !adbus_tri) viol++;
      if (!ftdi_rd) begin
        if (prev_rd) order_q.push_back(ORD_R);
        rd_run++;
        rd_exp = adbus_in;
      end else if (!prev_rd) begin
        last_rd_len = rd_run; rd_run = 0; rd_cnt++;
        rxq.push_back(rd_exp);
      end
      if (!ftdi_wr) begin
        wr_run++;
        wr_obs = adbus_out;
      end else if (!prev_wr) begin
        last_wr_len = wr_run; wr_run = 0; wr_cnt++;
        if (txq.size() == 0) sb_err++;
        else begin
          tmp_b = txq.pop_front();
          if (tmp_b !== wr_obs) sb_err++;
          else sb_tx_n++;
        end
      end
      if (adbus_tri) begin
        if (!prev_tri) order_q.push_back(ORD_W);
        tri_run++;
      end else if (prev_tri) begin
        last_tri_len = tri_run; tri_run = 0;
      end
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      if (rx_valid && rx_ready) begin
        if (rxq.size() == 0) sb_err++;
        else begin
          tmp_b = rxq.pop_front();
          if (tmp_b !== rx_data) sb_err++;
          else sb_rx_n++;
        end
      end
      if (!ftdi_rd || !ftdi_wr || adbus_tri) begin
        if (seen_act && quiet_run > 0 && quiet_run < min_gap) min_gap = quiet_run;
        quiet_run = 0;
        seen_act = 1'b1;
      end else begin
        quiet_run++;
      end
      prev_rd = ftdi_rd; prev_wr = ftdi_wr; prev_tri = adbus_tri;
    end
  end

  initial begin
    int n;
    reset = 1'b0; en = 1'b0; rxf = 1'b1; txe = 1'b1; adbus_in = 8'h00;
    rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;

    // Asynchronous reset values, checked before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("rst_rd", ftdi_rd, 1'b1);
    chk("rst_wr", ftdi_wr, 1'b1);
    chk("rst_tri", adbus_tri, 1'b0);
    chk("rst_adbus_out", adbus_out, 8'h00);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    tick(); tick();
    reset = 1'b0;

    // en=0 blocks reads; raising en starts RD# low on the next edge
    rxf = 1'b0; adbus_in = 8'hA5;
    repeat (6) tick();
    chk("en0_no_rd", ftdi_rd, 1'b1);
    chk("en0_idle", busy, 1'b0);
    en = 1'b1;
    #1 chk("en_rise_same_cycle", ftdi_rd, 1'b1);
    tick();
    chk("rd_low_c1", ftdi_rd, 1'b0);
    chk("rd_busy", busy, 1'b1);
    chk("rd_no_tri", adbus_tri, 1'b0);
    repeat (3) tick();
    chk("rd_low_c4", ftdi_rd, 1'b0);
    tick();
    chk("rd_end_high", ftdi_rd, 1'b1);
    chk("rd_valid", rx_valid, 1'b1);
    chk("rd_data", rx_data, 8'hA5);
    repeat (10) tick();
    chk("rd_valid_held", rx_valid, 1'b1);
    chk("rd_data_held", rx_data, 8'hA5);
    chk("rd_single", rd_cnt, 1);
    chk("rd_pulse_len", last_rd_len, 4);
    chk("rd_back_idle", busy, 1'b0);
    rxf = 1'b1;
    repeat (3) tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rx_drain", rx_valid, 1'b0);
    tick();

    // rxf falling -> rx_valid latency: 2 sync + 1 + RD_PULSE = 7
    adbus_in = 8'h5A; rxf = 1'b0;
    n = 0;
    while (rx_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("rd_latency", n, 7);
    chk("rd2_data", rx_data, 8'h5A);
    rxf = 1'b1;
    repeat (3) tick();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    chk("rd2_count", rd_cnt, 2);

    // Single write of 3C; en drops mid-write and the write still completes
    txe = 1'b0;
    repeat (3) tick();
    tx_data = 8'h3C; tx_valid = 1'b1;
    #1 chk("wr_tx_ready_pre", tx_ready, 1'b1);
    tick();
    tx_valid = 1'b0;
    chk("wr_tx_ready_drop", tx_ready, 1'b0);
    n = 0;
    while (adbus_tri !== 1'b1 && n < 10) begin tick(); n++; end
    chk("wr_start_delay", n, 1);
    chk("wr_setup_data", adbus_out, 8'h3C);
    chk("wr_setup_wr_high", ftdi_wr, 1'b1);
    tick();
    chk("wr_low", ftdi_wr, 1'b0);
    chk("wr_low_tri", adbus_tri, 1'b1);
    en = 1'b0;
    repeat (10) tick();
    chk("wr_tri_len", last_tri_len, 6);
    chk("wr_pulse_len", last_wr_len, 4);
    chk("wr_tx_ready_back", tx_ready, 1'b1);
    chk("wr_done_idle", busy, 1'b0);
    chk("wr_count", wr_cnt, 1);

    // With en low a pending byte waits; raising en releases it
    tx_data = 8'h99; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    repeat (8) tick();
    chk("en0_no_wr", busy, 1'b0);
    chk("en0_hold_full", tx_ready, 1'b0);
    en = 1'b1;
    repeat (14) tick();
    chk("wr2_count", wr_cnt, 2);
    chk("wr2_tx_ready", tx_ready, 1'b1);
    txe = 1'b1;

    // Contention after reset: read first, then strict alternation
    reset = 1'b1;
    tick(); tick();
    en = 1'b1; rxf = 1'b0; txe = 1'b0; tx_valid = 1'b1; tx_data = 8'hC3;
    rx_ready = 1'b1; adbus_in = 8'h77;
    order_q.delete();
    min_gap = 99;
    reset = 1'b0;
    n = 0;
    while (order_q.size() < 4 && n < 200) begin tick(); n++; end
    chk("cont_count", (order_q.size() >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("cont_order%0d", i), (order_q.size() > i) ? order_q[i] : 8'h00,
          (i % 2 == 0) ? ORD_R : ORD_W);
    chk("cont_gap", (min_gap >= 3) ? 1 : 0, 1);

    // Reset during WR_LOW cycle 2 releases strobes and bus immediately
    tx_valid = 1'b0; rxf = 1'b1; txe = 1'b1; rx_ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    txe = 1'b0;
    tx_data = 8'h5E; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    n = 0;
    while (ftdi_wr !== 1'b0 && n < 20) begin tick(); n++; end
    chk("rstwr_reached", ftdi_wr, 1'b0);
    tick();
    #5 reset = 1'b1;
    #1;
    chk("rstwr_wr", ftdi_wr, 1'b1);
    chk("rstwr_tri", adbus_tri, 1'b0);
    chk("rstwr_rd", ftdi_rd, 1'b1);
    chk("rstwr_tx_ready", tx_ready, 1'b1);
    chk("rstwr_busy", busy, 1'b0);
    tick(); tick();
    reset = 1'b0;
    txe = 1'b1;
    tick();

    // Random soak
    min_gap = 99;
    for (int i = 0; i < 600; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      rxf      = $urandom_range(0, 1);
      txe      = $urandom_range(0, 1);
      rx_ready = $urandom_range(0, 1);
      tx_valid = $urandom_range(0, 1);
      tx_data  = 8'($urandom);
      adbus_in = 8'($urandom);
      tick();
    end
    chk("rand_gap", (min_gap >= 3) ? 1 : 0, 1);
    chk("protocol_viol", viol, 0);
    chk("scoreboard_err", sb_err, 0);
    chk("sb_rx_seen", (sb_rx_n != 0) ? 1 : 0, 1);
    chk("sb_tx_seen", (sb_tx_n != 0) ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
